// File: rtl/if_prefetch.sv
// Instruction-fetch stage: generates the fetch PC, drives a synchronous ROM and
// buffers returned instructions in a small circular queue in front of decode.
module if_prefetch #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              excpt,
    input  logic [PC_W-1:0]   ejpc,
    input  logic              jCe,
    input  logic [PC_W-1:0]   jAddr,
    output logic              ce,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] rom_data,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    input  logic              id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_W-1:0]   q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;

    logic            accept;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            push;
    logic            pop;

    // An in-flight request reserves a slot, so the queue can never overflow.
    assign occupancy   = count + CW'(inflight);
    assign ce          = !rst && (occupancy < FULL);
    assign accept      = ce;

    assign redirect    = excpt || jCe;
    assign redirect_pc = excpt ? ejpc : jAddr;

    // A redirect discards returning data and overrides any pop at the same edge.
    assign push        = inflight && !redirect;
    assign pop         = id_valid && id_ready && !redirect;

    assign id_valid    = (count != '0);
    assign id_pc       = q_pc[rd_ptr];
    assign id_inst     = q_inst[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (accept) begin
            pc <= pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= accept && !redirect;
            if (accept) begin
                inflight_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= inflight_pc;
            q_inst[wr_ptr] <= rom_data;
        end
    end

endmodule
